// File: rtl/sobel_window_core.sv
// Streaming 3x3 Sobel edge detector fed one column of three row taps per beat.
// Three-stage pipeline: window + qualifier, Gx/Gy, edge magnitude / threshold.
module sobel_window_core #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int THRESHOLD  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] tap0_i,
  input  logic [DATA_WIDTH-1:0] tap1_i,
  input  logic [DATA_WIDTH-1:0] tap2_i,
  output logic [DATA_WIDTH-1:0] edge_o,
  output logic                  valid_o,
  output logic                  frame_done_o
);

  localparam int SW = DATA_WIDTH + 3;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [SW-1:0] SAT_MAX  = SW'((2 ** DATA_WIDTH) - 1);
  localparam logic [SW-1:0] THR      = SW'(THRESHOLD);

  // Handshake: valid_i has no ready; every cycle with valid_i high is one accepted
  // column beat, and valid_o is a one-cycle qualifier with no back-pressure.

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                           state_q, state_d;
  logic   [CW-1:0]                  col_q;
  logic   [RW-1:0]                  row_q;
  logic                             col_wrap, run;
  logic   [2:0][2:0][DATA_WIDTH-1:0] win_q;
  logic                             qual_q, last1_q;
  logic signed [SW-1:0]             gx_d, gy_d, gx_q, gy_q;
  logic                             v2_q, last2_q;
  logic   [SW-1:0]                  abs_x, abs_y, mag;
  logic   [DATA_WIDTH-1:0]          edge_d;

  assign col_wrap = (col_q == COL_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (valid_i) begin
      col_q <= col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap) row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= FILL;
    else          state_q <= state_d;
  end

  // RUN tracks row >= 2; it is entered leaving row 1 and left on frame wrap.
  always_comb begin
    state_d = state_q;
    if (valid_i && col_wrap) begin
      if (row_q == ROW_LAST)     state_d = FILL;
      else if (row_q == ROW_ONE) state_d = RUN;
    end
  end

  always_comb begin
    run = (state_q == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_q   <= '0;
      qual_q  <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      if (valid_i) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= tap2_i;
        win_q[1][2] <= tap1_i;
        win_q[2][2] <= tap0_i;
      end
      // Leftover columns from the previous row are masked out by col >= 2.
      qual_q  <= valid_i && run && (col_q >= COL_TWO);
      last1_q <= valid_i && run && col_wrap && (row_q == ROW_LAST);
    end
  end

  function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return signed'({3'b000, p});
  endfunction

  always_comb begin
    gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gx_q    <= '0;
      gy_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      v2_q    <= qual_q;
      last2_q <= last1_q;
    end
  end

  always_comb begin
    abs_x = gx_q[SW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y = gy_q[SW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag   = abs_x + abs_y;
    if (THRESHOLD > 0) edge_d = (mag >= THR) ? '1 : '0;
    else               edge_d = (mag > SAT_MAX) ? '1 : mag[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      edge_o       <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      edge_o       <= v2_q ? edge_d : '0;
      valid_o      <= v2_q;
      frame_done_o <= v2_q && last2_q;
    end
  end

endmodule

// File: tb/tb_sobel_window_core.sv
// Bench for sobel_window_core: an 8x6 image stream into a magnitude instance and a
// THRESHOLD=128 instance, checked against a pixel-level Sobel model and a point table.
module tb_sobel_window_core;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = (W - 2) * (H - 2);
  localparam int EW   = 41;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] tap0, tap1, tap2;
  logic [7:0] edge0, edge1;
  logic       vo0, vo1, fd0, fd1;

  always #5 clk = ~clk;

  sobel_window_core #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(0)) dut_mag (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .tap0_i(tap0), .tap1_i(tap1), .tap2_i(tap2),
    .edge_o(edge0), .valid_o(vo0), .frame_done_o(fd0));

  sobel_window_core #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(128)) dut_thr (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .tap0_i(tap0), .tap1_i(tap1), .tap2_i(tap2),
    .edge_o(edge1), .valid_o(vo1), .frame_done_o(fd1));

  int img [H][W];
  int cyc = 0;
  int checks = 0, errors = 0, pulses = 0, fd_pulses = 0;
  logic [7:0]    got0 [NPIX];
  logic [7:0]    got1 [NPIX];
  logic [EW-1:0] exp_q [$];

  typedef struct {
    int         kind;
    int         r;
    int         c;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t tbl [15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Sobel at centre (r,c) straight from the image: {frame_done, thr_edge, mag_edge}.
  function automatic logic [16:0] ref_pix(input int r, input int c);
    int gx = 0, gy = 0, mag;
    logic [7:0] e0, e1;
    for (int d = -1; d <= 1; d++) begin
      int wt = (d == 0) ? 2 : 1;
      gx += wt * (img[r+d][c+1] - img[r+d][c-1]);
      gy += wt * (img[r+1][c+d] - img[r-1][c+d]);
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    e0  = (mag > 255) ? 8'hff : 8'(mag);
    e1  = (mag >= 128) ? 8'hff : 8'h00;
    return {(r == H - 2 && c == W - 2), e1, e0};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n && (vo0 || vo1 || fd0 || fd1)) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", {28'd0, vo0, vo1, fd0, fd1}, 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("valid_mag", vo0, 1);
        check("valid_thr", vo1, 1);
        check("edge_mag", edge0, e[7:0]);
        check("edge_thr", edge1, e[15:8]);
        check("frame_done_mag", fd0, e[16]);
        check("frame_done_thr", fd1, e[16]);
        check("latency_edge", cyc, {8'd0, e[40:17]});
        got0[pulses % NPIX] = edge0;
        got1[pulses % NPIX] = edge1;
        pulses++;
        if (fd0) fd_pulses++;
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    tap0  = 8'($urandom_range(0, 255));
    tap1  = 8'($urandom_range(0, 255));
    tap2  = 8'($urandom_range(0, 255));
  endtask

  // Sampled on the next edge (cyc+1); valid_o is raised by the edge two later.
  task automatic beat(input int r, input int c);
    @(negedge clk);
    valid = 1'b1;
    tap0  = 8'(img[r][c]);
    tap1  = (r >= 1) ? 8'(img[r-1][c]) : 8'($urandom_range(0, 255));
    tap2  = (r >= 2) ? 8'(img[r-2][c]) : 8'($urandom_range(0, 255));
    if (r >= 2 && c >= 2) exp_q.push_back({24'(cyc + 3), ref_pix(r - 1, c - 1)});
  endtask

  task automatic drive_frame(input int gap_pct, input int stop_at);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(0, 99) < gap_pct) idle();
        beat(r, c);
        if (r * W + c == stop_at) return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      idle();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (4) idle();
  endtask

  task automatic frame_counts(input int frames);
    check("pulse_count", pulses, frames * NPIX);
    check("frame_done_count", fd_pulses, frames);
    pulses    = 0;
    fd_pulses = 0;
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c >= 4) ? 255 : 0;
          2:       img[r][c] = (r == 2 && c == 2) ? 50 : 0;
          default: img[r][c] = $urandom_range(0, 255);
        endcase
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {12'd0, vo0, vo1, fd0, fd1, edge0, edge1}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0, 1, 1, 8'd0, 8'd0};
    tbl[1]  = '{0, 4, 6, 8'd0, 8'd0};
    tbl[2]  = '{0, 2, 3, 8'd0, 8'd0};
    tbl[3]  = '{1, 2, 3, 8'd255, 8'd255};
    tbl[4]  = '{1, 2, 4, 8'd255, 8'd255};
    tbl[5]  = '{1, 3, 2, 8'd0, 8'd0};
    tbl[6]  = '{1, 4, 5, 8'd0, 8'd0};
    tbl[7]  = '{1, 1, 1, 8'd0, 8'd0};
    tbl[8]  = '{1, 3, 6, 8'd0, 8'd0};
    tbl[9]  = '{2, 2, 2, 8'd0, 8'd0};
    tbl[10] = '{2, 1, 2, 8'd100, 8'd0};
    tbl[11] = '{2, 2, 1, 8'd100, 8'd0};
    tbl[12] = '{2, 3, 3, 8'd100, 8'd0};
    tbl[13] = '{2, 1, 1, 8'd100, 8'd0};
    tbl[14] = '{2, 2, 3, 8'd100, 8'd0};

    rst_n = 1'b0;
    valid = 1'b0;
    tap0  = '0;
    tap1  = '0;
    tap2  = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    repeat (2) idle();

    // Constant, vertical step and impulse images with fixed point expectations.
    for (int k = 0; k < 3; k++) begin
      fill(k);
      drive_frame(0, -1);
      drain();
      frame_counts(1);
      foreach (tbl[i]) begin
        if (tbl[i].kind == k) begin
          check("table_edge_mag", got0[(tbl[i].r - 1) * (W - 2) + tbl[i].c - 1], tbl[i].e0);
          check("table_edge_thr", got1[(tbl[i].r - 1) * (W - 2) + tbl[i].c - 1], tbl[i].e1);
        end
      end
    end

    // Random image, two frames back to back with no idle cycle between them.
    fill(3);
    drive_frame(0, -1);
    drive_frame(0, -1);
    drain();
    frame_counts(2);

    // Random image with roughly 50% valid duty.
    fill(3);
    drive_frame(50, -1);
    drain();
    frame_counts(1);

    // Reset at row 3 col 5, then a clean frame from pixel (0,0).
    fill(3);
    drive_frame(0, 3 * W + 5);
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    exp_q.delete();
    pulses    = 0;
    fd_pulses = 0;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("mid_reset_outputs");
    end
    rst_n = 1'b1;
    repeat (3) idle();
    fill(3);
    drive_frame(0, -1);
    drain();
    frame_counts(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
